// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART receive engine.
// The optional parity stage is selected with the UART_RX_PARITY_EN macro.
package uart_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;

  localparam int DEFAULT_DIVISOR  = 868;
  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser with a falling-edge detector; flops reset high so an
// idle line never produces a spurious edge. Also usable for switch inputs.
module rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_cur;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_cur  <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_cur  <= r_meta;
      r_prev <= r_cur;
    end
  end

  // A line held low (e.g. after a break) cannot retrigger until it goes high.
  assign o_sync = r_cur;
  assign o_fall = r_prev & ~r_cur;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: 8 data bits LSB-first, 1 stop bit, ready/read byte handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_engine
  import uart_defs::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  input  logic       i_read,
  output logic [7:0] o_data,
  output logic       o_rdy,
  output logic       o_ferr,
  output logic       o_ovr,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_rdy;
  logic             r_ferr;
  logic             r_ovr;
  logic             r_busy;
  logic             w_sync;
  logic             w_fall;
  logic             w_cnt_zero;
  logic             w_par_err;

  rx_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (i_rx),
    .o_sync (w_sync),
    .o_fall (w_fall)
  );

  assign w_cnt_zero = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic r_par;
  assign w_par_err = (even_parity(r_shift) != r_par);
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= 8'h00;
      r_rdy     <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      // A read clears the flags; a commit later in this block takes priority.
      if (i_read && r_rdy) begin
        r_rdy  <= 1'b0;
        r_ferr <= 1'b0;
        r_ovr  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_cnt   <= CNT_HALF;
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_cnt_zero) begin
            if (!w_sync) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
              r_cnt     <= CNT_FULL;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_cnt_zero) begin
            r_shift[r_bit_idx] <= w_sync;
            r_cnt              <= CNT_FULL;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_cnt_zero) begin
            r_par   <= w_sync;
            r_cnt   <= CNT_FULL;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_cnt_zero) begin
            r_data <= r_shift;
            r_rdy  <= 1'b1;
            r_ferr <= ~w_sync | w_par_err;
            if (r_rdy && !i_read) begin
              r_ovr <= 1'b1;
            end else if (i_read) begin
              r_ovr <= 1'b0;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data = r_data;
  assign o_rdy  = r_rdy;
  assign o_ferr = r_ferr;
  assign o_ovr  = r_ovr;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine (DIVISOR=16): directed table, corner
// sequences and randomised frames against a frame-level reference model.
module tb_uart_rx_engine;

  localparam int D = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Mid-point of the stop bit, counted in clocks from the start-bit drive.
  localparam int STOP_MID = (NB - 1) * D + D / 2 + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rx;
  logic       i_read;
  logic [7:0] o_data;
  logic       o_rdy;
  logic       o_ferr;
  logic       o_ovr;
  logic       o_busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   rise_cyc;
  logic busy_seen;

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ferr;
  logic       m_ovr;

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    logic       read_after;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t tbl[5];

  uart_rx_engine #(.DIVISOR(D), .CNT_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_rx   (i_rx),
    .i_read (i_read),
    .o_data (o_data),
    .o_rdy  (o_rdy),
    .o_ferr (o_ferr),
    .o_ovr  (o_ovr),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Sends one frame; read_at>0 pulses i_read in that clock of the frame.
  task automatic send_frame(input logic [7:0] d, input logic stopb,
                            input logic par_bad, input int read_at);
    logic [11:0] bits;
    logic        prev;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^d) ^ par_bad;
    bits[10]  = stopb;
`else
    bits[9]   = stopb;
`endif
    rise_cyc  = -1;
    busy_seen = 1'b0;
    prev      = o_rdy;
    for (int c = 0; c < NB * D; c++) begin
      @(negedge clk);
      i_rx   = bits[c / D];
      i_read = (c + 1 == read_at);
      @(posedge clk);
      #1;
      if (o_busy) busy_seen = 1'b1;
      if (!prev && o_rdy && rise_cyc < 0) rise_cyc = c + 1;
      prev = o_rdy;
    end
    i_read = 1'b0;
    $display("frame: data=0x%02h stop=%0b par_bad=%0b read_at=%0d -> o_data=0x%02h rdy=%0b ferr=%0b ovr=%0b",
             d, stopb, par_bad, read_at, o_data, o_rdy, o_ferr, o_ovr);
  endtask

  task automatic idle_high(input int n);
    @(negedge clk);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    i_read = 1'b1;
    @(posedge clk);
    #1;
    i_read = 1'b0;
    $display("read: o_data=0x%02h rdy=%0b ferr=%0b ovr=%0b", o_data, o_rdy, o_ferr, o_ovr);
  endtask

  task automatic m_frame(input logic [7:0] d, input logic stopb, input logic par_bad);
    m_ovr  = m_rdy ? 1'b1 : m_ovr;
    m_rdy  = 1'b1;
    m_data = d;
    m_ferr = !stopb || par_bad;
  endtask

  task automatic m_read();
    if (m_rdy) begin
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
  endtask

  task automatic check_model(input string name);
    check(name, {o_data, o_rdy, o_ferr, o_ovr}, {m_data, m_rdy, m_ferr, m_ovr});
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    logic       rp;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};

    reset  = 1'b1;
    i_rx   = 1'b1;
    i_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {o_data, o_rdy, o_ferr, o_ovr, o_busy}, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    idle_high(4);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].d, tbl[i].stopb, 1'b0, 0);
      check($sformatf("tbl%0d frame", i), {o_data, o_rdy, o_ferr, o_ovr},
            {tbl[i].e_data, tbl[i].e_rdy, tbl[i].e_ferr, tbl[i].e_ovr});
      if (i == 0)
        check("rdy latency", (rise_cyc >= STOP_MID && rise_cyc <= STOP_MID + 3), 1);
      idle_high(6);
      if (tbl[i].read_after) begin
        pulse_read();
        check($sformatf("tbl%0d read", i), {o_data, o_rdy, o_ferr, o_ovr, o_busy},
              {tbl[i].e_data, 4'b0000});
      end
    end

    // Break: stop bit 0, then the line stays low
    send_frame(8'h55, 1'b0, 1'b0, 0);
    check("break frame", {o_data, o_rdy, o_ferr}, {8'h55, 2'b11});
    busy_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_busy) busy_seen = 1'b1;
    end
    check("break hold low no start", busy_seen, 0);
    idle_high(6);
    pulse_read();
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    check("after break frame", {o_data, o_rdy, o_ferr, o_ovr}, {8'h5A, 3'b100});
    idle_high(6);
    pulse_read();

    // Glitch: 4 low cycles only
    busy_seen = 1'b0;
    @(negedge clk);
    i_rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (o_busy) busy_seen = 1'b1;
    end
    i_rx = 1'b1;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (o_busy) busy_seen = 1'b1;
    end
    $display("glitch: busy_seen=%0b busy=%0b rdy=%0b", busy_seen, o_busy, o_rdy);
    check("glitch busy pulsed", busy_seen, 1);
    check("glitch idle no byte", {o_busy, o_rdy, o_ferr}, 3'b000);

    // Reset during data bit 4 with a pending byte
    send_frame(8'h99, 1'b1, 1'b0, 0);
    idle_high(4);
    for (int c = 0; c < 5 * D + 8; c++) begin
      @(negedge clk);
      i_rx = (c < D) ? 1'b0 : ((8'h6E >> (c / D - 1)) & 8'h01) != 0;
    end
    @(negedge clk);
    reset = 1'b1;
    i_rx  = 1'b1;
    #1;
    check("reset mid-frame immediate", {o_data, o_rdy, o_ferr, o_ovr, o_busy}, 12'h000);
    repeat (5) @(posedge clk);
    #1;
    check("reset held", {o_data, o_rdy, o_busy}, 10'h000);
    @(negedge clk);
    reset = 1'b0;
    idle_high(4);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    check("frame after reset", {o_data, o_rdy, o_ferr, o_ovr}, {8'h81, 3'b100});
    idle_high(6);

    // Read coinciding with commit: commit wins, overrun cleared
    send_frame(8'h24, 1'b0, 1'b0, STOP_MID + 2);
    check("read vs commit", {o_data, o_rdy, o_ferr, o_ovr}, {8'h24, 3'b110});
    idle_high(6);
    pulse_read();
    check("read after collide", {o_rdy, o_ferr, o_ovr}, 3'b000);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("parity bad", {o_data, o_rdy, o_ferr}, {8'h07, 2'b11});
    idle_high(6);
    pulse_read();
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("parity good", {o_data, o_rdy, o_ferr, o_ovr}, {8'h07, 3'b100});
    idle_high(6);
    pulse_read();
`endif

    // Random frames against the reference model
    send_frame(8'h11, 1'b1, 1'b0, 0);
    idle_high(6);
    pulse_read();
    m_data = 8'h11;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check_model("rand seed");
    for (int i = 0; i < 14; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      rp = ($urandom_range(0, 3) == 0);
`else
      rp = 1'b0;
`endif
      send_frame(rd, rs, rp, 0);
      m_frame(rd, rs, rp);
      check_model($sformatf("rand%0d frame", i));
      idle_high($urandom_range(4, 20));
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        m_read();
        check_model($sformatf("rand%0d read", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Serial receive stage directly downstream of the board I/O buffer block; consumes the buffered RX line and the buffered system clock/reset.
- Deserialises 8-bit asynchronous frames (start, 8 data LSB-first, optional parity, 1 stop) into a byte register.
- Presents the byte through a ready/read handshake suited to an 8-bit processor input port.

Parameters:
- DIVISOR, 868, clock cycles per bit (100 MHz / 115200); legal range 4..65535.
- CNT_W, 16, bit-time counter width; must hold DIVISOR-1.

Ports:
- clk  in  1  system clock (buffered)
- reset  in  1  asynchronous, active-high reset
- i_rx  in  1  buffered serial input, idle high, asynchronous to clk
- i_read  in  1  one-cycle pulse; consumer has taken o_data
- o_data  out  8  last received byte
- o_rdy  out  1  byte waiting, level
- o_ferr  out  1  framing error on the last frame
- o_ovr  out  1  frame completed while o_rdy was already 1
- o_busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: o_data=8'h00, o_rdy=0, o_ferr=0, o_ovr=0, o_busy=0, state=IDLE, counters=0, synchroniser flops=1.
- i_rx passes through a 2-flop synchroniser. Falling edge means sync_prev=1 and sync_cur=0. Input-to-detect latency is 2-3 cycles.
- IDLE: on falling edge, load counter with DIVISOR/2-1 (integer divide) and go to START.
- START: at counter=0, sample. If 0, go to DATA with bit_idx=0 and counter=DIVISOR-1. If 1, it is a glitch: go to IDLE with no flag change.
- DATA: at counter=0, shift the sample into bit[bit_idx] (LSB first) and reload DIVISOR-1. After bit_idx=7 go to PARITY (feature on) or STOP.
- STOP: at counter=0, sample, then commit in the same cycle:
  - o_data <= shift register.
  - o_rdy <= 1.
  - o_ferr <= (sample==0) or parity error.
  - o_ovr <= 1 if o_rdy was 1 and i_read was not asserted this cycle; otherwise hold.
  - Go to IDLE.
- After a stop bit of 0 (break), IDLE accepts no new start until the line has been sampled high; the edge detector enforces this.
- i_read: next cycle clears o_rdy, o_ferr and o_ovr.
- i_read in the same cycle as a commit: the commit wins. o_rdy stays 1, o_ferr takes the new value, o_ovr is cleared. A read pulse with o_rdy=0 is ignored.
- Overrun: the new byte overwrites o_data.
- Sampling lands mid-bit ±1 cycle plus synchroniser latency. The counter is an unsigned down-counter and never wraps below 0 because it reloads at 0.
- Reset mid-frame: everything returns to reset values immediately. A frame partially received before reset is discarded; the receiver resyncs on the next falling edge.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA, lasting one bit time with mid-bit sample. Expected parity is even: XOR of the 8 data bits equals the received parity bit. A mismatch sets o_ferr at commit.
- Undefined: no PARITY state; DATA goes straight to STOP; frames are 10 bits.

Decomposition:
- Shared package/include uart_defs:
  - State encodings IDLE/START/DATA/PARITY/STOP (3-bit localparams).
  - Default DIVISOR constant.
  - Frame length constants per macro setting.
- Sub-module rx_sync_edge: 2-flop synchroniser plus falling-edge detector, outputs sync_cur and fall. It is reusable for switch inputs.
- The FSM, counters and output registers stay in the top module.

Test Plan (DIVISOR=16 unless noted):
- Send 8'hA5, frame 160 cycles, no read.
  - o_rdy rises within 3 cycles of the stop-bit midpoint, o_data=8'hA5, o_ferr=0, o_ovr=0.
  - Pulse i_read: o_rdy=0 next cycle.
- Send 8'h3C then 8'hC3 without reading.
  - After the second frame: o_data=8'hC3, o_rdy=1, o_ovr=1.
  - Pulse i_read: all flags clear.
- Send 8'h55 with stop bit forced 0.
  - o_rdy=1, o_ferr=1, o_data=8'h55.
  - Hold the line low 40 cycles: no new frame is detected until the line returns high.
- Glitch: drive i_rx low for 4 cycles, then high.
  - FSM returns to IDLE from START, o_rdy stays 0, o_busy pulses then clears.
- Reset asserted at data bit 4 of a frame, released 5 cycles later.
  - All outputs 0 immediately, o_busy=0.
  - The next complete frame 8'h81 is received correctly.
- UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0.
  - o_ferr=1 (even parity expects 1).
  - Resend with parity 1: o_ferr=0, o_data=8'h07.
